vec_mem_sequencer: RTL and testbench

//  MEM-stage controller that serialises one vector load/store (16 x 16-bit lanes) into

---
 rtl/vec_mem_pkg.sv | 20 ++
 rtl/vec_lane_collector.sv | 58 +++++
 rtl/vec_mem_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and default sizes for the vector memory sequencer
package vec_mem_pkg;

  localparam int VMS_ELEMS  = 16;
  localparam int VMS_ELEM_W = 16;
  localparam int VMS_ADDR_W = 19;
  localparam int VMS_RD_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } vms_state_t;

  typedef logic [VMS_ELEM_W-1:0] lane_t;
  typedef lane_t [VMS_ELEMS-1:0] vec_t;

endpackage

// File: rtl/vec_lane_collector.sv
// rtl/vec_lane_collector.sv - tracks in-flight read lanes and merges returned RAM words into a vector
module vec_lane_collector
  import vec_mem_pkg::*;
#(
  parameter int ELEMS  = VMS_ELEMS,
  parameter int ELEM_W = VMS_ELEM_W,
  parameter int RD_LAT = VMS_RD_LAT
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_issue,
  input  logic [$clog2(ELEMS)-1:0]       i_issue_idx,
  input  logic [ELEM_W-1:0]              i_mem_q,
  output logic [ELEMS-1:0][ELEM_W-1:0]   o_acc_next
);

  localparam int IDX_W = $clog2(ELEMS);

  logic [RD_LAT-1:0]            r_vld;
  logic [RD_LAT-1:0][IDX_W-1:0] r_tag;
  logic [ELEMS-1:0][ELEM_W-1:0] r_acc;
  logic [ELEMS-1:0][ELEM_W-1:0] w_acc_next;

  // Delay each issued lane index so it lines up with the RAM word it requested
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= i_issue;
      r_tag[0] <= i_issue_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Merge the returning word into its lane; exposed so the last lane is visible the same cycle
  always_comb begin
    w_acc_next = r_acc;
    if (r_vld[RD_LAT-1]) begin
      w_acc_next[r_tag[RD_LAT-1]] = i_mem_q;
    end
  end

  // Working accumulator register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  assign o_acc_next = w_acc_next;

endmodule

// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - serialises one vector load/store into per-lane RAM accesses; optional VEC_MEM_STALL_COUNT_EN adds o_stall_cycles
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int ELEMS  = VMS_ELEMS,
  parameter int ELEM_W = VMS_ELEM_W,
  parameter int ADDR_W = VMS_ADDR_W,
  parameter int RD_LAT = VMS_RD_LAT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start_read,
  input  logic                         i_start_write,
  input  logic [ADDR_W-1:0]            i_base_addr,
  input  logic [ELEMS-1:0][ELEM_W-1:0] i_wr_vec,
  input  logic [4:0]                   i_rd_dest_in,
  input  logic [ELEM_W-1:0]            i_mem_q,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [ELEM_W-1:0]            o_mem_wd,
  output logic                         o_mem_we,
  output logic                         o_stall,
  output logic                         o_busy,
  output logic [ELEMS-1:0][ELEM_W-1:0] o_rd_vec,
  output logic                         o_rd_valid,
  output logic [4:0]                   o_rd_dest
`ifdef VEC_MEM_STALL_COUNT_EN
  ,
  output logic [ADDR_W-1:0]            o_stall_cycles
`endif
);

  localparam int                IDX_W      = $clog2(ELEMS);
  localparam logic [IDX_W-1:0]  LANE_LAST  = IDX_W'(ELEMS - 1);
  localparam logic [IDX_W-1:0]  DRAIN_LAST = IDX_W'(RD_LAT - 1);

  vms_state_t                   r_state;
  vms_state_t                   w_next;
  logic [IDX_W-1:0]             r_idx;
  logic [ADDR_W-1:0]            r_base;
  logic [ELEMS-1:0][ELEM_W-1:0] r_wr_vec;
  logic [4:0]                   r_dest_pend;
  logic                         r_is_load;
  logic [ELEMS-1:0][ELEM_W-1:0] r_rd_vec;
  logic [4:0]                   r_rd_dest;
  logic [ADDR_W-1:0]            w_addr;
  logic                         w_issue;
  logic                         w_finish_load;
  logic [ELEMS-1:0][ELEM_W-1:0] w_acc_next;

  assign w_addr        = r_base + ADDR_W'(r_idx);
  assign w_finish_load = (r_state == S_DRAIN) && (w_next == S_DONE);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and RAM-side outputs
  always_comb begin
    w_next     = r_state;
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_wd   = '0;
    o_stall    = 1'b0;
    o_rd_valid = 1'b0;
    w_issue    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_stall = i_start_write | i_start_read;
        if (i_start_write) begin
          w_next = S_WRITE;
        end else if (i_start_read) begin
          w_next = S_READ;
        end
      end
      S_WRITE: begin
        o_stall    = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = w_addr;
        o_mem_wd   = r_wr_vec[r_idx];
        if (r_idx == LANE_LAST) begin
          w_next = S_DONE;
        end
      end
      S_READ: begin
        o_stall    = 1'b1;
        o_mem_addr = w_addr;
        w_issue    = 1'b1;
        if (r_idx == LANE_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_stall = 1'b1;
        if (r_idx == DRAIN_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_rd_valid = r_is_load;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Lane counter (reused as drain counter) and latching of the request at start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_base      <= '0;
      r_wr_vec    <= '0;
      r_dest_pend <= '0;
      r_is_load   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (i_start_write) begin
            r_base    <= i_base_addr;
            r_wr_vec  <= i_wr_vec;
            r_is_load <= 1'b0;
          end else if (i_start_read) begin
            r_base      <= i_base_addr;
            r_dest_pend <= i_rd_dest_in;
            r_is_load   <= 1'b1;
          end
        end
        S_WRITE, S_READ: begin
          r_idx <= (r_idx == LANE_LAST) ? '0 : r_idx + 1'b1;
        end
        S_DRAIN: begin
          r_idx <= (r_idx == DRAIN_LAST) ? '0 : r_idx + 1'b1;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  vec_lane_collector #(
    .ELEMS  (ELEMS),
    .ELEM_W (ELEM_W),
    .RD_LAT (RD_LAT)
  ) u_collector (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_issue     (w_issue),
    .i_issue_idx (r_idx),
    .i_mem_q     (i_mem_q),
    .o_acc_next  (w_acc_next)
  );

  // Publish the load result only when the whole vector has arrived
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vec  <= '0;
      r_rd_dest <= '0;
    end else if (w_finish_load) begin
      r_rd_vec  <= w_acc_next;
      r_rd_dest <= r_dest_pend;
    end
  end

  assign o_rd_vec  = r_rd_vec;
  assign o_rd_dest = r_rd_dest;
  assign o_busy    = (r_state != S_IDLE);

`ifdef VEC_MEM_STALL_COUNT_EN
  logic [ADDR_W-1:0] r_stall_cycles;

  // Saturating count of burst stall cycles: ELEMS per store, ELEMS+RD_LAT per load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_WRITE || r_state == S_READ || r_state == S_DRAIN) &&
                 (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - directed self-checking bench for vec_mem_sequencer with a behavioural RAM
module tb_vec_mem_sequencer;
  import vec_mem_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start_read;
  logic              start_write;
  logic [18:0]       base_addr;
  vec_t              wr_vec;
  logic [4:0]        rd_dest_in;
  logic [15:0]       mem_q;
  logic [18:0]       mem_addr;
  logic [15:0]       mem_wd;
  logic              mem_we;
  logic              stall;
  logic              busy;
  vec_t              rd_vec;
  logic              rd_valid;
  logic [4:0]        rd_dest;
`ifdef VEC_MEM_STALL_COUNT_EN
  logic [18:0]       stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_rdv    = 0;

  logic [15:0] ram [logic [18:0]];

  vec_mem_sequencer u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_read  (start_read),
    .i_start_write (start_write),
    .i_base_addr   (base_addr),
    .i_wr_vec      (wr_vec),
    .i_rd_dest_in  (rd_dest_in),
    .i_mem_q       (mem_q),
    .o_mem_addr    (mem_addr),
    .o_mem_wd      (mem_wd),
    .o_mem_we      (mem_we),
    .o_stall       (stall),
    .o_busy        (busy),
    .o_rd_vec      (rd_vec),
    .o_rd_valid    (rd_valid),
    .o_rd_dest     (rd_dest)
`ifdef VEC_MEM_STALL_COUNT_EN
    ,
    .o_stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_q <= ram.exists(mem_addr) ? ram[mem_addr] : 16'h0000;
    if (mem_we) ram[mem_addr] = mem_wd;
  end

  always @(negedge clk) if (rd_valid) n_rdv++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ram_rd(input logic [18:0] a);
    return ram.exists(a) ? ram[a] : 16'h0000;
  endfunction

  task automatic run_store(input logic [18:0] base, input logic [15:0] first, input bit both);
    logic [18:0] a;
    @(negedge clk);
    base_addr = base;
    for (int i = 0; i < 16; i++) wr_vec[i] = first + 16'(i);
    rd_dest_in  = 5'd9;
    start_write = 1'b1;
    start_read  = both;
    #1;
    check("st_start_stall", stall, 1'b1);
    check("st_start_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = base + 19'(i);
      check("st_we", mem_we, 1'b1);
      check("st_addr", mem_addr, a);
      check("st_wd", mem_wd, first + 16'(i));
      check("st_stall", stall, 1'b1);
      start_write = 1'b0;
      start_read  = 1'b0;
    end
    @(negedge clk);
    check("st_done_stall", stall, 1'b0);
    check("st_done_busy", busy, 1'b1);
    check("st_done_we", mem_we, 1'b0);
    check("st_done_rdv", rd_valid, 1'b0);
    @(negedge clk);
    check("st_idle_busy", busy, 1'b0);
  endtask

  task automatic run_load(input logic [18:0] base, input logic [4:0] dest, input logic [15:0] first);
    vec_t exp_v;
    int   n;
    bit   we_seen;
    for (int i = 0; i < 16; i++) exp_v[i] = first + 16'(i);
    @(negedge clk);
    base_addr   = base;
    rd_dest_in  = dest;
    start_read  = 1'b1;
    #1;
    check("ld_start_stall", stall, 1'b1);
    n = 0;
    we_seen = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start_read = 1'b0;
      we_seen |= mem_we;
      if (rd_valid) break;
    end
    check("ld_latency", n, 18);
    check("ld_no_we", we_seen, 1'b0);
    check("ld_vec", rd_vec, exp_v);
    check("ld_dest", rd_dest, dest);
    check("ld_done_stall", stall, 1'b0);
    @(negedge clk);
    check("ld_pulse_1cyc", rd_valid, 1'b0);
    check("ld_vec_hold", rd_vec, exp_v);
    check("ld_idle_busy", busy, 1'b0);
  endtask

  initial begin
    int rdv0;
    int cnt;
    logic [18:0] sc0;
    rst_n       = 1'b0;
    start_read  = 1'b0;
    start_write = 1'b0;
    base_addr   = '0;
    wr_vec      = '0;
    rd_dest_in  = '0;
    sc0         = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 19'h0);
    check("rst_wd", mem_wd, 16'h0);
    check("rst_rdv", rd_valid, 1'b0);
    check("rst_vec", rd_vec, 256'h0);
    check("rst_dest", rd_dest, 5'h0);
    rst_n = 1'b1;

`ifdef VEC_MEM_STALL_COUNT_EN
    sc0 = stall_cycles;
    check("sc_reset", sc0, 19'h0);
`endif

    // store then load back the same vector
    run_store(19'h00100, 16'hA000, 1'b0);
    check("ram_0x100", ram_rd(19'h00100), 16'hA000);
    check("ram_0x10F", ram_rd(19'h0010F), 16'hA00F);
    run_load(19'h00100, 5'd5, 16'hA000);
`ifdef VEC_MEM_STALL_COUNT_EN
    check("sc_store_load", stall_cycles - sc0, 19'd33);
`endif

    // address wrap past all-ones
    run_store(19'h7FFF8, 16'hB000, 1'b0);
    check("wrap_top", ram_rd(19'h7FFFF), 16'hB007);
    check("wrap_zero", ram_rd(19'h00000), 16'hB008);
    check("wrap_7", ram_rd(19'h00007), 16'hB00F);
    run_load(19'h7FFF8, 5'd31, 16'hB000);

    // simultaneous starts: write wins, no load completion
    rdv0 = n_rdv;
    run_store(19'h00200, 16'hD000, 1'b1);
    repeat (20) @(negedge clk);
    check("both_no_rdv", n_rdv - rdv0, 0);
    check("both_dest_kept", rd_dest, 5'd31);
    check("both_ram", ram_rd(19'h0020F), 16'hD00F);

    // reset in the middle of a store
    @(negedge clk);
    base_addr   = 19'h03000;
    for (int i = 0; i < 16; i++) wr_vec[i] = 16'hC000 + 16'(i);
    start_write = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      start_write = 1'b0;
    end
    check("mid_addr_lane7", mem_addr, 19'h03007);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", mem_addr, 19'h0);
    check("mid_rst_vec", rd_vec, 256'h0);
    check("mid_rst_dest", rd_dest, 5'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 7; i++) if (ram_rd(19'h03000 + 19'(i)) == 16'hC000 + 16'(i)) cnt++;
    check("mid_lanes_0_6", cnt, 7);
    cnt = 0;
    for (int i = 8; i < 16; i++) if (ram.exists(19'h03000 + 19'(i))) cnt++;
    check("mid_lanes_8_15", cnt, 0);
    run_store(19'h03000, 16'hE000, 1'b0);
    run_load(19'h03000, 5'd12, 16'hE000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
